// File: rtl/cpu_pkg.sv
// Shared types and constants for the SimpleCPU controller: FSM state encoding,
// opcode values and error codes.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_ADD,
        S_LOC,
        S_SUB,
        S_JMZ,
        S_JNZ,
        S_NOT,
        S_JMP,
        S_HALT,
        S_ERROR
    } t_cntrl_fsm_state;

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_LOC   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_JMZ   = 4'd5;
    localparam logic [3:0] OP_NOT   = 4'd6;
    localparam logic [3:0] OP_JMP   = 4'd7;
    localparam logic [3:0] OP_JNZ   = 4'd8;
    localparam logic [3:0] OP_HALT  = 4'd9;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLOP   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // States that wait on a memory acknowledge and are guarded by the watchdog.
    function automatic logic is_wait_state(input t_cntrl_fsm_state s);
        return (s == S_FETCH) || (s == S_LOAD) || (s == S_STORE) || (s == S_NOT);
    endfunction

endpackage

// File: rtl/controller_fsm_p_if.sv
// Instruction- and data-memory handshake bundle between the controller
// (master) and the memory side (slave).
interface controller_fsm_p_if #(
    parameter int DATA_ADDR_W = 8
);
    logic                   I_rd;
    logic                   I_ack;
    logic [DATA_ADDR_W-1:0] D_addr;
    logic                   D_rd;
    logic                   D_wr;
    logic                   D_ack;

    modport master (
        output I_rd, D_addr, D_rd, D_wr,
        input  I_ack, D_ack
    );

    modport slave (
        input  I_rd, D_addr, D_rd, D_wr,
        output I_ack, D_ack
    );
endinterface

// File: rtl/controller_fsm_p_wait_timer.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT-1 is reached, holding there until cleared.
module wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int             CW   = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_d, cnt_q;

    assign expired = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/controller_fsm_p.sv
// SimpleCPU control unit: fetch/decode/execute sequencer with ack-based memory
// handshakes, a wait-state watchdog and a sticky error state.
module controller_fsm_p
    import cpu_pkg::*;
#(
    parameter int INSTR_W     = 16,
    parameter int REG_ADDR_W  = 4,
    parameter int DATA_ADDR_W = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INSTR_W-1:0]     instruction,
    input  logic                   RF_Rp_zero,
    input  logic                   run,
    controller_fsm_p_if.master     mem,
    output logic                   PC_clr,
    output logic                   PC_inc,
    output logic                   PC_ld,
    output logic                   IR_ld,
    output logic [REG_ADDR_W-1:0]  RF_W_addr,
    output logic [REG_ADDR_W-1:0]  RF_Rp_addr,
    output logic [REG_ADDR_W-1:0]  RF_Rq_addr,
    output logic                   RF_W_wr,
    output logic                   RF_Rp_rd,
    output logic                   RF_Rq_rd,
    output logic                   RF_s,
    output logic                   RF_cons,
    output logic                   RF_ext,
    output logic                   alu_s0,
    output logic [DATA_ADDR_W-1:0] Val_cons,
    output logic                   halted,
    output logic                   err,
    output logic [1:0]             err_code
);
    t_cntrl_fsm_state state_d, state_q;
    logic [1:0]       err_code_d, err_code_q;

    logic [3:0]             op;
    logic [REG_ADDR_W-1:0]  ra, rb, rc;
    logic [DATA_ADDR_W-1:0] d_field;

    assign op      = instruction[INSTR_W-1 -: 4];
    assign ra      = instruction[INSTR_W-5 -: REG_ADDR_W];
    assign rb      = instruction[2*REG_ADDR_W-1 : REG_ADDR_W];
    assign rc      = instruction[REG_ADDR_W-1 : 0];
    assign d_field = instruction[DATA_ADDR_W-1 : 0];

    logic wd_ack, wd_clear, wd_enable, wd_expired;

    // FETCH waits on the instruction memory; the other wait states on data memory.
    assign wd_ack    = (state_q == S_FETCH) ? mem.I_ack : mem.D_ack;
    assign wd_enable = is_wait_state(state_q) && !wd_ack;
    assign wd_clear  = (state_d != state_q);

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        err_code_d = err_code_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem.I_ack) begin
                    state_d = S_DECODE;
                end else if (wd_expired) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD:  state_d = S_LOAD;
                    OP_STORE: state_d = S_STORE;
                    OP_ADD:   state_d = S_ADD;
                    OP_LOC:   state_d = S_LOC;
                    OP_SUB:   state_d = S_SUB;
                    OP_JMZ:   state_d = S_JMZ;
                    OP_NOT:   state_d = S_NOT;
                    OP_JMP:   state_d = S_JMP;
                    OP_JNZ:   state_d = S_JNZ;
                    OP_HALT:  state_d = S_HALT;
                    default: begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_ILLOP;
                    end
                endcase
            end
            S_LOAD, S_STORE, S_NOT: begin
                // An ack arriving on the expiry cycle still completes the access.
                if (mem.D_ack) begin
                    state_d = S_FETCH;
                end else if (wd_expired) begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            S_ADD, S_SUB, S_LOC, S_JMP: state_d = S_FETCH;
            S_JMZ:   state_d = RF_Rp_zero ? S_JMP : S_FETCH;
            S_JNZ:   state_d = RF_Rp_zero ? S_FETCH : S_JMP;
            S_HALT:  state_d = run ? S_FETCH : S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        PC_clr     = 1'b0;
        PC_inc     = 1'b0;
        PC_ld      = 1'b0;
        IR_ld      = 1'b0;
        mem.I_rd   = 1'b0;
        mem.D_addr = '0;
        mem.D_rd   = 1'b0;
        mem.D_wr   = 1'b0;
        RF_W_addr  = '0;
        RF_Rp_addr = '0;
        RF_Rq_addr = '0;
        RF_W_wr    = 1'b0;
        RF_Rp_rd   = 1'b0;
        RF_Rq_rd   = 1'b0;
        RF_s       = 1'b0;
        RF_cons    = 1'b0;
        RF_ext     = 1'b0;
        alu_s0     = 1'b1;
        Val_cons   = '0;
        halted     = 1'b0;
        case (state_q)
            S_INIT:  PC_clr = 1'b1;
            S_FETCH: begin
                mem.I_rd = 1'b1;
                IR_ld    = mem.I_ack;
                PC_inc   = mem.I_ack;
            end
            S_LOAD, S_NOT: begin
                mem.D_addr = d_field;
                mem.D_rd   = 1'b1;
                RF_W_addr  = ra;
                RF_s       = 1'b1;
                RF_ext     = (state_q == S_NOT);
                RF_W_wr    = mem.D_ack;
            end
            S_STORE: begin
                mem.D_addr = d_field;
                mem.D_wr   = 1'b1;
                RF_Rp_addr = ra;
                RF_Rp_rd   = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Rp_addr = rb;
                RF_Rq_addr = rc;
                RF_Rp_rd   = 1'b1;
                RF_Rq_rd   = 1'b1;
                RF_W_addr  = ra;
                RF_W_wr    = 1'b1;
                alu_s0     = (state_q == S_ADD);
            end
            S_LOC: begin
                RF_W_addr = ra;
                RF_W_wr   = 1'b1;
                RF_cons   = 1'b1;
                Val_cons  = d_field;
            end
            S_JMZ, S_JNZ: begin
                RF_Rp_addr = ra;
                RF_Rp_rd   = 1'b1;
            end
            S_JMP:   PC_ld  = 1'b1;
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign err      = (state_q == S_ERROR);
    assign err_code = err_code_q;
endmodule

// File: tb/tb_controller_fsm_p.sv
// Self-checking bench for controller_fsm_p: directed test-plan steps plus random
// instruction streams checked cycle by cycle against an instruction-level model.
module tb_controller_fsm_p;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic       pc_clr, pc_inc, pc_ld, i_rd, ir_ld;
        logic [7:0] d_addr;
        logic       d_rd, d_wr;
        logic [3:0] w_addr, rp_addr, rq_addr;
        logic       w_wr, rp_rd, rq_rd, s, cons, ext, alu_s0;
        logic [7:0] val_cons;
        logic       halted, err;
        logic [1:0] err_code;
    } t_out;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        rp_zero = 1'b0;
    logic        run = 1'b0;
    logic        PC_clr, PC_inc, PC_ld, IR_ld;
    logic [3:0]  RF_W_addr, RF_Rp_addr, RF_Rq_addr;
    logic        RF_W_wr, RF_Rp_rd, RF_Rq_rd, RF_s, RF_cons, RF_ext, alu_s0;
    logic [7:0]  Val_cons;
    logic        halted, err;
    logic [1:0]  err_code;

    int errors = 0;
    int checks = 0;

    controller_fsm_p_if #(.DATA_ADDR_W(8)) bus ();

    controller_fsm_p #(
        .INSTR_W(16), .REG_ADDR_W(4), .DATA_ADDR_W(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instr), .RF_Rp_zero(rp_zero), .run(run),
        .mem(bus),
        .PC_clr(PC_clr), .PC_inc(PC_inc), .PC_ld(PC_ld), .IR_ld(IR_ld),
        .RF_W_addr(RF_W_addr), .RF_Rp_addr(RF_Rp_addr), .RF_Rq_addr(RF_Rq_addr),
        .RF_W_wr(RF_W_wr), .RF_Rp_rd(RF_Rp_rd), .RF_Rq_rd(RF_Rq_rd),
        .RF_s(RF_s), .RF_cons(RF_cons), .RF_ext(RF_ext), .alu_s0(alu_s0),
        .Val_cons(Val_cons), .halted(halted), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    function automatic t_out idle();
        t_out o;
        o = '0;
        o.alu_s0 = 1'b1;
        return o;
    endfunction

    function automatic t_out observed();
        t_out o;
        o.pc_clr = PC_clr;   o.pc_inc = PC_inc;     o.pc_ld = PC_ld;
        o.i_rd = bus.I_rd;   o.ir_ld = IR_ld;       o.d_addr = bus.D_addr;
        o.d_rd = bus.D_rd;   o.d_wr = bus.D_wr;     o.w_addr = RF_W_addr;
        o.rp_addr = RF_Rp_addr; o.rq_addr = RF_Rq_addr; o.w_wr = RF_W_wr;
        o.rp_rd = RF_Rp_rd;  o.rq_rd = RF_Rq_rd;    o.s = RF_s;
        o.cons = RF_cons;    o.ext = RF_ext;        o.alu_s0 = alu_s0;
        o.val_cons = Val_cons; o.halted = halted;   o.err = err;
        o.err_code = err_code;
        return o;
    endfunction

    task automatic chk_now(input t_out exp, input string tag);
        t_out got;
        got = observed();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Inputs for the current cycle are already driven; compare mid-cycle, then
    // advance to just after the next rising edge.
    task automatic chk(input t_out exp, input string tag);
        @(negedge clk);
        chk_now(exp, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        t_out rv;
        rv = idle();
        rv.pc_clr = 1'b1;
        bus.I_ack = 1'b0; bus.D_ack = 1'b0; run = 1'b0; rp_zero = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_now(rv, "reset_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk(rv, "init_pc_clr");
    endtask

    task automatic error_cycles(input logic [1:0] code, input int n);
        t_out e;
        e = idle();
        e.err = 1'b1;
        e.err_code = code;
        for (int k = 0; k < n; k++) begin
            bus.I_ack = 1'($urandom); bus.D_ack = 1'($urandom);
            run = 1'($urandom); rp_zero = 1'($urandom);
            chk(e, "error_state");
        end
        bus.I_ack = 1'b0; bus.D_ack = 1'b0; run = 1'b0;
    endtask

    // Instruction fetch: ack arrives after 'waits' idle cycles; waits >= TIMEOUT
    // means never, which must end in the timeout error.
    task automatic fetch(input logic [15:0] ins, input int waits, output bit timed_out);
        t_out e;
        bit   ack;
        timed_out = 1'b1;
        for (int w = 0; w < TIMEOUT; w++) begin
            ack = (w == waits);
            bus.I_ack = ack;
            bus.D_ack = 1'($urandom);
            run = 1'($urandom);
            if (ack) instr = ins;
            e = idle();
            e.i_rd = 1'b1;
            e.ir_ld = ack;
            e.pc_inc = ack;
            chk(e, "fetch");
            if (ack) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.I_ack = 1'b0; bus.D_ack = 1'b0; run = 1'b0;
        if (timed_out) error_cycles(2'b10, 3);
    endtask

    task automatic mem_access(input logic [15:0] ins, input int waits, output bit timed_out);
        t_out e;
        bit   ack;
        timed_out = 1'b1;
        for (int w = 0; w < TIMEOUT; w++) begin
            ack = (w == waits);
            bus.D_ack = ack;
            run = 1'($urandom);
            e = idle();
            e.d_addr = ins[7:0];
            if (ins[15:12] == 4'd1) begin
                e.d_wr = 1'b1;
                e.rp_addr = ins[11:8];
                e.rp_rd = 1'b1;
            end else begin
                e.d_rd = 1'b1;
                e.w_addr = ins[11:8];
                e.s = 1'b1;
                e.ext = (ins[15:12] == 4'd6);
                e.w_wr = ack;
            end
            chk(e, "mem_access");
            if (ack) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.D_ack = 1'b0; run = 1'b0;
        if (timed_out) error_cycles(2'b10, 3);
    endtask

    // Instruction-level model: one call executes one instruction end to end.
    task automatic run_instr(input logic [15:0] ins, input int fwaits, input int mwaits,
                             input bit zero, input int halt_wait, output bit in_err);
        t_out e;
        bit   to;
        logic [3:0] op;
        op = ins[15:12];
        in_err = 1'b0;
        fetch(ins, fwaits, to);
        if (to) begin
            in_err = 1'b1;
            return;
        end
        run = 1'($urandom);
        chk(idle(), "decode");
        run = 1'b0;
        e = idle();
        case (op)
            4'd0, 4'd1, 4'd6: begin
                mem_access(ins, mwaits, to);
                in_err = to;
            end
            4'd2, 4'd4: begin
                e.rp_addr = ins[7:4]; e.rq_addr = ins[3:0];
                e.rp_rd = 1'b1; e.rq_rd = 1'b1;
                e.w_addr = ins[11:8]; e.w_wr = 1'b1;
                e.alu_s0 = (op == 4'd2);
                chk(e, "add_sub");
            end
            4'd3: begin
                e.w_addr = ins[11:8]; e.w_wr = 1'b1; e.cons = 1'b1;
                e.val_cons = ins[7:0];
                chk(e, "loc");
            end
            4'd5, 4'd8: begin
                rp_zero = zero;
                e.rp_addr = ins[11:8]; e.rp_rd = 1'b1;
                chk(e, "branch_test");
                rp_zero = 1'b0;
                if ((op == 4'd5) == zero) begin
                    e = idle();
                    e.pc_ld = 1'b1;
                    chk(e, "branch_taken");
                end
            end
            4'd7: begin
                e.pc_ld = 1'b1;
                chk(e, "jmp");
            end
            4'd9: begin
                e.halted = 1'b1;
                for (int k = 0; k <= halt_wait; k++) begin
                    run = (k == halt_wait);
                    chk(e, "halt");
                end
                run = 1'b0;
            end
            default: begin
                error_cycles(2'b01, 4);
                in_err = 1'b1;
            end
        endcase
    endtask

    initial begin
        bit         ie;
        t_out       e;
        logic [3:0] op;
        bus.I_ack = 1'b0;
        bus.D_ack = 1'b0;

        do_reset();
        run_instr(16'h335A, 0, 0, 1'b0, 0, ie);   // LOC r3,0x5A
        run_instr(16'h0210, 0, 3, 1'b0, 0, ie);   // LOAD r2,0x10 with 3 waits
        run_instr(16'h4145, 0, 0, 1'b0, 0, ie);   // SUB r1,r4,r5
        run_instr(16'h5600, 0, 0, 1'b1, 0, ie);   // JMZ r6, zero -> taken
        run_instr(16'h8600, 0, 0, 1'b1, 0, ie);   // JNZ r6, zero -> not taken
        run_instr(16'h9000, 1, 0, 1'b0, 4, ie);   // HALT, run on 5th cycle
        run_instr(16'h0733, 0, TIMEOUT - 1, 1'b0, 0, ie);  // ack on expiry cycle wins
        run_instr(16'h6A21, 2, 1, 1'b0, 0, ie);   // NOT
        run_instr(16'h1C44, 0, 2, 1'b0, 0, ie);   // STORE
        run_instr(16'h7000, 0, 0, 1'b0, 0, ie);   // JMP

        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 9));
            run_instr({op, 12'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom), $urandom_range(0, 4), ie);
            if (ie) do_reset();
        end

        run_instr(16'h1255, 0, TIMEOUT, 1'b0, 0, ie);  // STORE never acked
        do_reset();
        run_instr(16'h3000, TIMEOUT, 0, 1'b0, 0, ie);  // fetch never acked
        do_reset();
        run_instr(16'hB123, 0, 0, 1'b0, 0, ie);        // illegal opcode
        do_reset();

        // Reset in the middle of a LOAD wait must drop D_rd at once.
        fetch(16'h0210, 0, ie);
        chk(idle(), "decode");
        e = idle();
        e.d_addr = 8'h10; e.d_rd = 1'b1; e.w_addr = 4'd2; e.s = 1'b1;
        chk(e, "load_wait");
        chk(e, "load_wait");
        do_reset();
        run_instr(16'h3E07, 0, 0, 1'b0, 0, ie);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
